// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter for the single register-file write port: loads win the port,
// losing ALU writes are queued in order, and a load scoreboard drives the decode stall.
module regfile_wb_arbiter #(
    parameter int ADDRESS_WIDTH = 5,
    parameter int DATA_WIDTH    = 32,
    parameter int BUF_DEPTH     = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     alu_valid,
    input  logic [ADDRESS_WIDTH-1:0] alu_rd,
    input  logic [DATA_WIDTH-1:0]    alu_data,
    output logic                     alu_ready,
    input  logic                     ld_valid,
    input  logic [ADDRESS_WIDTH-1:0] ld_rd,
    input  logic [DATA_WIDTH-1:0]    ld_data,
    input  logic                     ld_issue,
    input  logic [ADDRESS_WIDTH-1:0] ld_issue_rd,
    input  logic [ADDRESS_WIDTH-1:0] rs1,
    input  logic [ADDRESS_WIDTH-1:0] rs2,
    output logic                     stall,
    output logic                     wr_en,
    output logic [ADDRESS_WIDTH-1:0] wr_addr,
    output logic [DATA_WIDTH-1:0]    wr_data,
    output logic [1:0]               pending_cnt
);
    localparam int         NREG = 2 ** ADDRESS_WIDTH;
    localparam logic [1:0] FULL = BUF_DEPTH[1:0];

    logic [NREG-1:0]          r_busy;
    logic [ADDRESS_WIDTH-1:0] r_buf_rd   [2];
    logic [DATA_WIDTH-1:0]    r_buf_data [2];
    logic [1:0]               r_cnt;
    logic                     r_wr_en;
    logic [ADDRESS_WIDTH-1:0] r_wr_addr;
    logic [DATA_WIDTH-1:0]    r_wr_data;

    logic                     w_alu_acc;
    logic                     w_pop;
    logic                     w_direct;
    logic                     w_push;
    logic [1:0]               w_tail;
    logic                     w_grant_en;
    logic [ADDRESS_WIDTH-1:0] w_grant_addr;
    logic [DATA_WIDTH-1:0]    w_grant_data;
    logic [ADDRESS_WIDTH-1:0] w_nxt_rd   [2];
    logic [DATA_WIDTH-1:0]    w_nxt_data [2];
    logic [1:0]               w_nxt_cnt;
    logic [NREG-1:0]          w_nxt_busy;

    // Ready looks only at current occupancy, so a full buffer refuses even while popping.
    assign alu_ready = (r_cnt != FULL);
    assign w_alu_acc = alu_valid && alu_ready;
    assign w_pop     = !ld_valid && (r_cnt != 2'd0);
    assign w_direct  = !ld_valid && (r_cnt == 2'd0) && w_alu_acc;
    assign w_push    = w_alu_acc && !w_direct && (alu_rd != '0);
    assign w_tail    = r_cnt - {1'b0, w_pop};

    always_comb begin
        w_grant_en   = 1'b0;
        w_grant_addr = '0;
        w_grant_data = '0;
        if (ld_valid) begin
            w_grant_en   = (ld_rd != '0);
            w_grant_addr = ld_rd;
            w_grant_data = ld_data;
        end else if (w_pop) begin
            w_grant_en   = 1'b1;
            w_grant_addr = r_buf_rd[0];
            w_grant_data = r_buf_data[0];
        end else if (w_direct) begin
            w_grant_en   = (alu_rd != '0);
            w_grant_addr = alu_rd;
            w_grant_data = alu_data;
        end
    end

    always_comb begin
        w_nxt_rd[0]   = r_buf_rd[0];
        w_nxt_rd[1]   = r_buf_rd[1];
        w_nxt_data[0] = r_buf_data[0];
        w_nxt_data[1] = r_buf_data[1];
        if (w_pop) begin
            w_nxt_rd[0]   = r_buf_rd[1];
            w_nxt_data[0] = r_buf_data[1];
        end
        if (w_push) begin
            w_nxt_rd[w_tail[0]]   = alu_rd;
            w_nxt_data[w_tail[0]] = alu_data;
        end
        w_nxt_cnt = r_cnt + {1'b0, w_push} - {1'b0, w_pop};
    end

    // Clear before set so a reissue to the returning register stays outstanding.
    always_comb begin
        w_nxt_busy = r_busy;
        if (ld_valid) begin
            w_nxt_busy[ld_rd] = 1'b0;
        end
        if (ld_issue && (ld_issue_rd != '0)) begin
            w_nxt_busy[ld_issue_rd] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy        <= '0;
            r_cnt         <= '0;
            r_buf_rd[0]   <= '0;
            r_buf_rd[1]   <= '0;
            r_buf_data[0] <= '0;
            r_buf_data[1] <= '0;
            r_wr_en       <= 1'b0;
            r_wr_addr     <= '0;
            r_wr_data     <= '0;
        end else begin
            r_busy        <= w_nxt_busy;
            r_cnt         <= w_nxt_cnt;
            r_buf_rd[0]   <= w_nxt_rd[0];
            r_buf_rd[1]   <= w_nxt_rd[1];
            r_buf_data[0] <= w_nxt_data[0];
            r_buf_data[1] <= w_nxt_data[1];
            r_wr_en       <= w_grant_en;
            if (w_grant_en) begin
                r_wr_addr <= w_grant_addr;
                r_wr_data <= w_grant_data;
            end
        end
    end

    function automatic logic hazard(input logic [ADDRESS_WIDTH-1:0] s);
        logic h;
        h = r_busy[s]
            || ((r_cnt != 2'd0) && (r_buf_rd[0] == s))
            || ((r_cnt == 2'd2) && (r_buf_rd[1] == s))
            || (r_wr_en && (r_wr_addr == s));
        return (s != '0) && h;
    endfunction

    assign stall       = hazard(rs1) || hazard(rs2);
    assign wr_en       = r_wr_en;
    assign wr_addr     = r_wr_addr;
    assign wr_data     = r_wr_data;
    assign pending_cnt = r_cnt;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: directed scenarios plus random traffic
// compared against a queue-based write-back model.
module tb_regfile_wb_arbiter;
    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        alu_valid, ld_valid, ld_issue;
    logic [4:0]  alu_rd, ld_rd, ld_issue_rd, rs1, rs2;
    logic [31:0] alu_data, ld_data;
    logic        alu_ready, stall, wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic [1:0]  pending_cnt;

    always #5 clk = ~clk;

    regfile_wb_arbiter #(.ADDRESS_WIDTH(5), .DATA_WIDTH(32), .BUF_DEPTH(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
        .ld_valid(ld_valid), .ld_rd(ld_rd), .ld_data(ld_data),
        .ld_issue(ld_issue), .ld_issue_rd(ld_issue_rd),
        .rs1(rs1), .rs2(rs2), .stall(stall),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .pending_cnt(pending_cnt)
    );

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Reference model: pending ALU writes as a queue, outstanding loads as a bit per register.
    typedef struct {
        logic [4:0]  rd;
        logic [31:0] d;
    } ent_t;
    ent_t        q[$];
    bit          mbusy[32];
    bit          m_en;
    logic [4:0]  m_addr;
    logic [31:0] m_data;

    function automatic bit m_haz(input logic [4:0] s);
        if (s == 0) return 0;
        if (mbusy[s]) return 1;
        foreach (q[i]) if (q[i].rd == s) return 1;
        if (m_en && m_addr == s) return 1;
        return 0;
    endfunction

    task automatic model_reset();
        q.delete();
        foreach (mbusy[i]) mbusy[i] = 0;
        m_en = 0;
    endtask

    task automatic model_step();
        bit   ready, acc;
        ent_t e;
        ready = (q.size() != 2);
        acc   = alu_valid && ready;
        m_en  = 0;
        if (ld_valid) begin
            m_en = (ld_rd != 0); m_addr = ld_rd; m_data = ld_data;
            mbusy[ld_rd] = 0;
            if (acc && alu_rd != 0) begin e.rd = alu_rd; e.d = alu_data; q.push_back(e); end
        end else if (q.size() > 0) begin
            e = q.pop_front();
            m_en = 1; m_addr = e.rd; m_data = e.d;
            if (acc && alu_rd != 0) begin e.rd = alu_rd; e.d = alu_data; q.push_back(e); end
        end else if (acc) begin
            m_en = (alu_rd != 0); m_addr = alu_rd; m_data = alu_data;
        end
        if (ld_issue && ld_issue_rd != 0) mbusy[ld_issue_rd] = 1;
    endtask

    task automatic idle_in();
        alu_valid = 0; alu_rd = 0; alu_data = 0;
        ld_valid = 0; ld_rd = 0; ld_data = 0;
        ld_issue = 0; ld_issue_rd = 0; rs1 = 0; rs2 = 0;
    endtask

    // Inputs are set by the caller just after an edge; combinational outputs checked first.
    task automatic cycle();
        #1;
        check("alu_ready", alu_ready, (q.size() != 2));
        check("stall", stall, (m_haz(rs1) || m_haz(rs2)));
        model_step();
        @(posedge clk);
        #1;
        check("wr_en", wr_en, m_en);
        if (m_en) begin
            check("wr_addr", wr_addr, m_addr);
            check("wr_data", wr_data, m_data);
        end
        check("pending_cnt", pending_cnt, q.size());
    endtask

    task automatic do_reset();
        idle_in();
        rst_n = 0;
        #1;
        check("rst_wr_en", wr_en, 0);
        check("rst_pending", pending_cnt, 0);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int nxt;
        idle_in();
        #2;
        do_reset();
        check("reset_wr_addr", wr_addr, 0);
        check("reset_wr_data", wr_data, 0);

        // Single ALU write, no contention
        alu_valid = 1; alu_rd = 5; alu_data = 32'hAA;
        cycle();
        check("t1_wr_addr", wr_addr, 5);
        check("t1_wr_data", wr_data, 32'hAA);
        idle_in(); cycle();

        // ALU and load collide: load first, ALU next edge
        alu_valid = 1; alu_rd = 3; alu_data = 32'h11;
        ld_valid = 1; ld_rd = 7; ld_data = 32'h22;
        cycle();
        check("t2_first_addr", wr_addr, 7);
        check("t2_cnt", pending_cnt, 1);
        idle_in(); cycle();
        check("t2_second_addr", wr_addr, 3);

        // Three loads back to back while ALU streams rd 1,2,3
        nxt = 1;
        for (int c = 0; c < 8; c++) begin
            idle_in();
            ld_valid = (c < 3); ld_rd = 5'(12 + c); ld_data = 32'h100 + c;
            alu_valid = (nxt <= 3); alu_rd = 5'(nxt); alu_data = 32'h200 + nxt;
            if (alu_valid && q.size() != 2) begin
                cycle(); nxt++;
            end else begin
                cycle();
            end
            if (c == 2) check("t3_full", pending_cnt, 2);
        end

        // Writes to x0 are swallowed
        idle_in();
        alu_valid = 1; alu_rd = 0; alu_data = 32'hFFFF_FFFF;
        ld_valid = 1; ld_rd = 0; ld_data = 32'h1234;
        cycle();
        check("t4_x0_wr_en", wr_en, 0);
        idle_in(); cycle();

        // Scoreboard: issue, stall, return, clear; set wins over clear
        ld_issue = 1; ld_issue_rd = 9;
        cycle();
        idle_in(); rs1 = 9; cycle();
        check("t5_stall_busy", stall, 1);
        rs1 = 0; rs2 = 0; #1; check("t5_x0_nostall", stall, 0); cycle();
        rs1 = 9; ld_valid = 1; ld_rd = 9; ld_data = 32'h99; cycle();
        idle_in(); rs1 = 9; cycle();
        idle_in(); rs1 = 9; cycle();
        ld_issue = 1; ld_issue_rd = 9; ld_valid = 1; ld_rd = 9; ld_data = 32'h9A; cycle();
        idle_in(); cycle(); cycle();
        rs2 = 9; #1; check("t5_set_wins", stall, 1);
        ld_valid = 1; ld_rd = 9; cycle();
        idle_in(); cycle(); cycle();

        // Buffered write discarded by mid-operation reset
        alu_valid = 1; alu_rd = 4; alu_data = 32'h44;
        ld_valid = 1; ld_rd = 8; ld_data = 32'h88;
        cycle();
        idle_in(); ld_valid = 1; ld_rd = 10; cycle();
        check("t6_held", pending_cnt, 1);
        do_reset();
        for (int c = 0; c < 3; c++) begin
            idle_in(); cycle();
        end

        // Random traffic
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 499) == 0) begin
                do_reset();
            end
            alu_valid   = ($urandom_range(0, 99) < 60);
            alu_rd      = 5'($urandom_range(0, 7));
            alu_data    = $urandom;
            ld_valid    = ($urandom_range(0, 99) < 40);
            ld_rd       = 5'($urandom_range(0, 7));
            ld_data     = $urandom;
            ld_issue    = ($urandom_range(0, 99) < 30);
            ld_issue_rd = 5'($urandom_range(0, 7));
            rs1         = 5'($urandom_range(0, 9));
            rs2         = 5'($urandom_range(0, 9));
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
Write-back arbiter and load scoreboard for the single-write-port register file (32 x 32-bit, one write port WE3/WD3/rd). Two producers compete for that port: the ALU result path and the load-data return path. The block grants the port one write per cycle with load priority and holds losing ALU writes in a 2-entry in-order buffer. It also tracks registers with outstanding loads and raises a decode stall on RAW hazards.

Parameters:
ADDRESS_WIDTH, 5, register index width (2**ADDRESS_WIDTH registers)
DATA_WIDTH, 32, register data width
BUF_DEPTH, 2, ALU pending-write buffer entries (fixed at 2 for this revision)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
alu_valid  input  1  ALU write-back request
alu_rd  input  ADDRESS_WIDTH  ALU destination register
alu_data  input  DATA_WIDTH  ALU result
alu_ready  output  1  ALU request accepted this cycle when high with alu_valid
ld_valid  input  1  load data return (always accepted, never back-pressured)
ld_rd  input  ADDRESS_WIDTH  load destination register
ld_data  input  DATA_WIDTH  load data
ld_issue  input  1  load issued to memory this cycle
ld_issue_rd  input  ADDRESS_WIDTH  destination of issued load
rs1  input  ADDRESS_WIDTH  decode-stage source 1
rs2  input  ADDRESS_WIDTH  decode-stage source 2
stall  output  1  decode must hold (combinational)
wr_en  output  1  drives regfile WE3 (registered)
wr_addr  output  ADDRESS_WIDTH  drives regfile rd (registered)
wr_data  output  DATA_WIDTH  drives regfile WD3 (registered)
pending_cnt  output  2  ALU buffer occupancy, 0..2

Behaviour:
- Reset (async assert, sync release on clk): wr_en=0, wr_addr=0, wr_data=0, buffer emptied (pending_cnt=0), all busy bits 0. Asserting rst_n mid-operation discards buffered writes and outstanding-load state immediately.
- Grant priority each cycle: (1) ld_valid; (2) buffer head; (3) incoming ALU request when the buffer is empty. A granted write appears on wr_en/wr_addr/wr_data at the next rising edge (1-cycle latency). wr_en deasserts on any cycle with no grant.
- alu_ready = (pending_cnt != 2). It does not depend on a same-cycle pop.
- Accepted ALU request not granted this cycle: pushed to the buffer tail. Buffer drains in FIFO order, so ALU writes stay in program order.
- Push and pop in the same cycle: occupancy unchanged. When pending_cnt=2 and a head pop occurs, alu_ready still reads 0 that cycle.
- rd == 0 (ALU or load): request accepted, no write generated, no buffer entry, wr_en stays 0. x0 is never written.
- Scoreboard busy[31:0]:
  - ld_issue with ld_issue_rd != 0 sets busy[ld_issue_rd].
  - Load grant clears busy[ld_rd].
  - Set and clear of the same index in one cycle: set wins (new load outstanding).
- stall = OR over s in {rs1, rs2} of (s != 0) AND (busy[s] OR s matches rd of any valid buffer entry OR (wr_en AND s == wr_addr)). The last term covers the write committing this edge; there is no forwarding path.
- Load returns on consecutive cycles with a full buffer: the buffer does not drain and alu_ready stays 0 until a load-free cycle.
- Width rules: data passes through unmodified. Indices compare at ADDRESS_WIDTH bits. pending_cnt saturates by construction (push is blocked at 2).

Test Plan:
- Reset, then alu_valid with rd=5, data=0x0000_00AA, no load -> next edge wr_en=1, wr_addr=5, wr_data=0xAA; pending_cnt stays 0.
- Same cycle alu(rd=3, 0x11) and ld(rd=7, 0x22) -> edge1 writes x7=0x22 and pending_cnt=1; edge2 writes x3=0x11 and pending_cnt=0.
- ld_valid held 3 cycles while ALU sends rd=1,2,3 every cycle -> alu_ready falls after two pushes (pending_cnt=2), rd=3 is held off; after the loads end, writes occur as x1, x2, x3 in order.
- alu rd=0 data=0xFFFF_FFFF and ld rd=0 -> wr_en never asserts; pending_cnt=0.
- ld_issue rd=9, then rs1=9 -> stall=1 until the cycle after the ld rd=9 grant; rs1=0 with busy state -> stall=0. ld_issue rd=9 in the same cycle as the ld rd=9 return -> busy[9] stays 1.
- Buffer holding rd=4 with rst_n pulsed low -> wr_en=0 and pending_cnt=0 immediately; no write to x4 after release.
